// File: rtl/msg_send_fsm.sv
// Streams one of MSG_COUNT ROM-resident messages to a UART TX over the ldtxdata/txempty
// handshake; a message ends at a 0x00 byte or after MAX_LEN bytes, and can be aborted.
module msg_send_fsm #(
    parameter int unsigned MSG_COUNT = 4,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SEL_W     = $clog2(MSG_COUNT),
    parameter int unsigned IDX_W     = $clog2(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SEL_W-1:0]       msg_sel,
    input  logic                   abort,
    input  logic                   txempty,
    input  logic [DATA_W-1:0]      rom_data,
    output logic [SEL_W+IDX_W-1:0] rom_addr,
    output logic [DATA_W-1:0]      txdata,
    output logic                   ldtxdata,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [IDX_W:0]         sent_count
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] CHECK    = 3'd2;
    localparam logic [2:0] LOAD     = 3'd3;
    localparam logic [2:0] WAITLOAD = 3'd4;
    localparam logic [2:0] WAITSEND = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

    logic [2:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] txdata_q, txdata_d;
    logic              ldtxdata_q, ldtxdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [IDX_W:0]    sent_count_q, sent_count_d;
    logic              abort_hit;

    // Abort only matters while a message is actually in flight.
    always_comb begin
        abort_hit = 1'b0;
        case (state_q)
            FETCH, CHECK, LOAD, WAITLOAD, WAITSEND: abort_hit = abort;
            default:                                abort_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        idx_d        = idx_q;
        txdata_d     = txdata_q;
        aborted_d    = aborted_q;
        sent_count_d = sent_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d        = msg_sel;
                    idx_d        = '0;
                    sent_count_d = '0;
                    aborted_d    = 1'b0;
                    state_d      = FETCH;
                end
            end
            FETCH: state_d = CHECK;
            CHECK: begin
                if (rom_data == '0) begin
                    state_d = FINISH;
                end else begin
                    txdata_d = rom_data;
                    state_d  = LOAD;
                end
            end
            LOAD:     state_d = WAITLOAD;
            WAITLOAD: state_d = WAITSEND;
            WAITSEND: begin
                if (txempty) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = FETCH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort outranks both txempty and the terminator; a byte already strobed stays counted.
        if (abort_hit) begin
            state_d   = FINISH;
            aborted_d = 1'b1;
            txdata_d  = txdata_q;
            idx_d     = idx_q;
        end

        // Outputs are registered from the next state so they line up with the state itself.
        ldtxdata_d = (state_d == LOAD);
        done_d     = (state_d == FINISH);
        busy_d     = (state_d != IDLE);
        if (state_d == LOAD) begin
            sent_count_d = sent_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            idx_q        <= '0;
            txdata_q     <= '0;
            ldtxdata_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            txdata_q     <= txdata_d;
            ldtxdata_q   <= ldtxdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign rom_addr   = {sel_q, idx_q};
    assign txdata     = txdata_q;
    assign ldtxdata   = ldtxdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_msg_send_fsm.sv
// Scoreboard bench for msg_send_fsm: stimulus pushes expected bytes and run results,
// a negedge monitor pops and compares on every ldtxdata and done.
module tb_msg_send_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] msg_sel;
    logic       abort;
    logic       txempty;
    logic [7:0] rom_data;
    logic [6:0] rom_addr;
    logic [7:0] txdata;
    logic       ldtxdata;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [5:0] sent_count;

    msg_send_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg_sel    (msg_sel),
        .abort      (abort),
        .txempty    (txempty),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .txdata     (txdata),
        .ldtxdata   (ldtxdata),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [6:0] addr;
    } byte_t;

    typedef struct {
        int ab;
        int cnt;
        int lat;
    } run_t;

    byte_t byte_q[$];
    run_t  run_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int tx_delay = 0;
    int tx_cnt = 0;

    logic [7:0] rom [128];
    logic [7:0] m1 [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // UART TX model: txempty drops for tx_delay negedges after each load strobe.
    always @(negedge clk) begin
        if (ldtxdata && tx_delay > 0) begin
            tx_cnt  = tx_delay;
            txempty = 1'b0;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) txempty = 1'b1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        byte_t b;
        run_t  r;
        cyc++;
        if (rst_n === 1'b1 && start === 1'b1 && busy === 1'b0) accept_cyc = cyc;
        if (ldtxdata === 1'b1) begin
            if (byte_q.size() == 0) begin
                chk("unexpected_ldtxdata", 32'(txdata), 32'hFFFF);
            end else begin
                b = byte_q.pop_front();
                chk("txdata", 32'(txdata), 32'(b.data));
                chk("rom_addr", 32'(rom_addr), 32'(b.addr));
            end
        end
        if (done === 1'b1) begin
            if (run_q.size() == 0) begin
                chk("unexpected_done", 32'(sent_count), 32'hFFFF);
            end else begin
                r = run_q.pop_front();
                chk("aborted", 32'(aborted), 32'(r.ab));
                chk("sent_count", 32'(sent_count), 32'(r.cnt));
                chk("done_latency", 32'(cyc - accept_cyc), 32'(r.lat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input int d);
        tx_delay = d;
        msg_sel  = 2'(sel);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Leaves the bench in the IDLE cycle following done.
    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        tick();
    endtask

    task automatic push_m1(input int n);
        for (int i = 0; i < n; i++) byte_q.push_back('{data: m1[i], addr: 7'(32 + i)});
    endtask

    task automatic push_run(input int ab, input int cnt, input int lat);
        run_t r;
        r.ab  = ab;
        r.cnt = cnt;
        r.lat = lat;
        run_q.push_back(r);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ldtxdata"}, 32'(ldtxdata), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_aborted"}, 32'(aborted), 32'd0);
        chk({tag, "_txdata"}, 32'(txdata), 32'd0);
        chk({tag, "_sent_count"}, 32'(sent_count), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        foreach (rom[i]) rom[i] = 8'h00;
        m1[0] = 8'h47; m1[1] = 8'h45; m1[2] = 8'h54; m1[3] = 8'h20;
        m1[4] = 8'h2F; m1[5] = 8'h0D; m1[6] = 8'h0A;
        for (int i = 0; i < 7; i++) rom[32 + i] = m1[i];
        for (int i = 0; i < 32; i++) rom[64 + i] = 8'(8'h41 + i);
        rom[96] = 8'h4F;
        rom[97] = 8'h4B;
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        start   = 1'b1;
        msg_sel = 2'd2;
        abort   = 1'b0;
        txempty = 1'b1;

        // Reset held with start asserted
        tick();
        tick();
        chk_reset_outputs("reset");
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        // msg1, txempty always high
        push_m1(7);
        push_run(0, 7, 38);
        send(1, 0);
        chk("busy_running", 32'(busy), 32'd1);
        wait_done(200);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("txdata_hold", 32'(txdata), 32'h0A);
        chk("count_hold", 32'(sent_count), 32'd7);

        // Empty message: terminator at index 0, txdata keeps the previous byte
        push_run(0, 0, 3);
        send(0, 0);
        wait_done(50);
        chk("txdata_hold_empty", 32'(txdata), 32'h0A);

        // msg1, TX slow by 3 extra cycles per byte
        push_m1(7);
        push_run(0, 7, 59);
        send(1, 5);
        wait_done(300);
        tx_delay = 0;

        // msg2, full length without terminator
        for (int i = 0; i < 32; i++) byte_q.push_back('{data: 8'(8'h41 + i), addr: 7'(64 + i)});
        push_run(0, 32, 161);
        send(2, 0);
        wait_done(400);

        // Abort in WAITSEND of byte 3 while txempty=1
        push_m1(3);
        push_run(1, 3, 16);
        send(1, 0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (ldtxdata === 1'b1) n++;
            if (n == 3) break;
            tick();
        end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(20);
        chk("aborted_hold", 32'(aborted), 32'd1);
        chk("count_hold_abort", 32'(sent_count), 32'd3);
        chk("txdata_hold_abort", 32'(txdata), 32'h54);

        // Normal run after abort
        push_m1(7);
        push_run(0, 7, 38);
        send(1, 0);
        wait_done(200);
        chk("aborted_cleared", 32'(aborted), 32'd0);

        // start pulses with msg_sel=2 mid-run are ignored
        push_m1(7);
        push_run(0, 7, 38);
        send(1, 0);
        msg_sel = 2'd2;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);

        // Back-to-back: start held through done of msg3, then msg1
        byte_q.push_back('{data: 8'h4F, addr: 7'd96});
        byte_q.push_back('{data: 8'h4B, addr: 7'd97});
        push_run(0, 2, 13);
        push_m1(7);
        push_run(0, 7, 38);
        msg_sel = 2'd3;
        start   = 1'b1;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_first_done", 32'(done), 32'd1);
        msg_sel = 2'd1;
        tick();
        tick();
        start = 1'b0;
        wait_done(200);

        // Reset in the middle of a message: no done pulse
        push_m1(2);
        send(1, 0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (ldtxdata === 1'b1) n++;
            if (n == 2) break;
            tick();
        end
        tick();
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        repeat (5) tick();

        chk("bytes_left", 32'(byte_q.size()), 32'd0);
        chk("runs_left", 32'(run_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msg_send_fsm.md
# msg_send_fsm

Parametrised successor to the fixed-string UART request sender. It streams one of `MSG_COUNT` selectable messages to the UART transmitter, one byte at a time, using the `ldtxdata`/`txempty` handshake. Message bytes come from an external synchronous ROM. A message ends at a 0x00 terminator or after `MAX_LEN` bytes, whichever comes first. The block adds abort, busy and byte-count reporting, and sits between the system controller and the UART TX.

## Interface
- `MSG_COUNT`, default 4: number of selectable messages; power of two, ≥2.
- `MAX_LEN`, default 32: maximum bytes per message and ROM slot size; power of two, ≥2.
- `DATA_W`, default 8: character width.
- `SEL_W`, default $clog2(MSG_COUNT): message select width (derived).
- `IDX_W`, default $clog2(MAX_LEN): byte index width (derived).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request to send a message; sampled only in IDLE.
- `msg_sel`  in  SEL_W  message index; latched when `start` is accepted.
- `abort`  in  1  terminates an in-progress message.
- `txempty`  in  1  UART TX holding register empty.
- `rom_data`  in  DATA_W  ROM read data; valid one cycle after `rom_addr`.
- `rom_addr`  out  SEL_W+IDX_W  registered address, formed as {sel_q, idx}.
- `txdata`  out  DATA_W  byte presented to the UART TX.
- `ldtxdata`  out  1  one-cycle load strobe to the UART TX.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion or abort.
- `aborted`  out  1  high together with `done` when the run ended by abort.
- `sent_count`  out  IDX_W+1  number of `ldtxdata` pulses in the current or last run.

## Operation
- States: IDLE, FETCH, CHECK, LOAD, WAITLOAD, WAITSEND, FINISH.
- IDLE:
  - When `start`=1: latch `msg_sel` into `sel_q`, set idx=0, clear `sent_count` and `aborted`, go to FETCH.
  - `start` is ignored in every other state. `msg_sel` changes while busy have no effect.
- FETCH: `rom_addr`={sel_q, idx}. Go to CHECK unconditionally.
- CHECK: `rom_data` is valid.
  - If 0x00: go to FINISH, no byte sent.
  - Otherwise: capture it into `txdata`, go to LOAD.
- LOAD: `ldtxdata`=1 for exactly this cycle; `sent_count` increments. Go to WAITLOAD.
- WAITLOAD: one cycle so the TX can drop `txempty`; `txempty` is ignored here. Go to WAITSEND.
- WAITSEND: hold while `txempty`=0. When `txempty`=1:
  - If idx==MAX_LEN-1: go to FINISH.
  - Otherwise: idx++, go to FETCH.
- FINISH: `done`=1 for this cycle, `aborted`=1 if entered via abort. Go to IDLE.
- Abort:
  - `abort`=1 in FETCH, CHECK, LOAD, WAITLOAD or WAITSEND forces FINISH next, with `aborted`=1.
  - Abort has priority over `txempty` and over the 0x00 terminator.
  - A byte already strobed stays counted.
  - `abort` is ignored in IDLE and FINISH.
- `txdata` holds its last value between bytes and after completion.
- `sent_count` and `aborted` hold after FINISH until the next accepted `start`.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=IDLE; `ldtxdata`=0, `done`=0, `busy`=0, `aborted`=0, `txdata`=0, `sent_count`=0, `rom_addr`=0, idx=0, sel_q=0.
- Reset mid-message takes effect at that edge. No `done` pulse is produced.
- `start` accepted at edge k:
  - FETCH at k+1, CHECK at k+2.
  - First `ldtxdata` pulse at k+3.
  - WAITLOAD at k+4, WAITSEND at k+5.
- With `txempty` held 1, each byte takes 5 cycles (FETCH→WAITSEND). For an N-byte message terminated by 0x00 (N<MAX_LEN), `done` is high 5N+3 cycles after `start` acceptance.
- A full-length message (no terminator) never fetches index MAX_LEN; `done` follows the last WAITSEND by one cycle.
- `busy` rises one cycle after the `start` edge and falls the cycle after `done`.
- Back-to-back runs: `start` held high during the `done` cycle is accepted in the following IDLE cycle.

## Test plan
All scenarios use default parameters; the ROM model has msg1="GET /\r\n" (7 bytes, then 0x00) and msg2 with 32 nonzero bytes 0x41+i.
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 → state IDLE, all outputs 0, no `ldtxdata`.
- msg1, `txempty` held 1 → 7 `ldtxdata` pulses with bytes 0x47 0x45 0x54 0x20 0x2F 0x0D 0x0A; `done` 38 cycles after acceptance; `sent_count`=7; `aborted`=0.
- msg1, `txempty` held 0 for 3 extra cycles per byte → stays in WAITSEND until `txempty`=1; no duplicate strobes; `sent_count`=7.
- msg2, `txempty`=1 → 32 bytes 0x41..0x60; no fetch at index 32; `sent_count`=32; `done` once.
- Abort: assert `abort` in the WAITSEND of byte 3 of msg1, same cycle as `txempty`=1 → FINISH next; `done`=1, `aborted`=1, `sent_count`=3; following `start` with msg_sel=1 runs normally.
- `start` pulses with msg_sel=2 during a msg1 run → ignored; msg1 completes unchanged.
